// File: rtl/timer_pkg.sv
// Shared state encoding, BCD constants, default parameters and BCD helpers
// for the mm:ss timer core.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] BCD_59          = 8'h59;
   localparam logic [7:0] BCD_ZERO        = 8'h00;
   localparam logic [7:0] DEF_MIN_VAL     = 8'h23;
   localparam logic [7:0] DEF_SEC_VAL     = 8'h59;
   localparam logic [7:0] MAX_MIN_VAL     = 8'h99;
   localparam int         LED_W_VAL       = 16;
   localparam int         ALARM_TICKS_VAL = 10;

   function automatic logic bcd_valid(input logic [7:0] v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_step_up(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == max)
         r = BCD_ZERO;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] bcd_step_down(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == BCD_ZERO)
         r = max;
      else if (v[3:0] == 4'd0)
         r = {v[7:4] - 4'd1, 4'd9};
      else
         r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at mod_max; wrap flags the cycle whose
// inc/dec crosses the boundary so a higher digit pair can carry on the same edge.
module bcd_mod_counter
   import timer_pkg::*;
#(
   parameter logic [7:0] RST_VAL = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       inc,
   input  logic       dec,
   input  logic [7:0] mod_max,
   output logic [7:0] cnt,
   output logic       wrap
);

   logic [7:0] r_val;
   logic [7:0] w_next;

   assign wrap = !load && ((inc && (r_val == mod_max)) ||
                           (!inc && dec && (r_val == BCD_ZERO)));
   assign cnt  = r_val;

   // next count: load beats inc, inc beats dec
   always_comb begin
      w_next = r_val;
      if (load)
         w_next = load_val;
      else if (inc)
         w_next = bcd_step_up(r_val, mod_max);
      else if (dec)
         w_next = bcd_step_down(r_val, mod_max);
      else
         w_next = r_val;
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_val <= RST_VAL;
      else
         r_val <= w_next;
   end

endmodule

// File: rtl/countdown_timer_core_chk.sv
// Parameter sanity checker for countdown_timer_core: BCD-legal presets and a
// representable alarm tick budget.
module countdown_timer_core_chk
   import timer_pkg::*;
#(
   parameter logic [7:0] DEF_MIN     = DEF_MIN_VAL,
   parameter logic [7:0] DEF_SEC     = DEF_SEC_VAL,
   parameter logic [7:0] MAX_MIN     = MAX_MIN_VAL,
   parameter int         ALARM_TICKS = ALARM_TICKS_VAL
) (
   input logic clk,
   input logic rst
);

   // trap illegal configurations once out of reset
   always @(posedge clk) begin
      if (!rst) begin
         assert (bcd_valid(DEF_MIN) && bcd_valid(DEF_SEC) && bcd_valid(MAX_MIN) &&
                 (DEF_SEC <= BCD_59) && (DEF_MIN <= MAX_MIN) &&
                 (ALARM_TICKS >= 32'sd1) && (ALARM_TICKS <= 32'sd256));
      end
   end

endmodule

// File: rtl/countdown_timer_core.sv
// mm:ss timer core: run/pause/stop FSM, BCD preset, up/down count, alarm LEDs.
// Optional ALARM_BLINK_EN: blinking alarm with auto-return after ALARM_TICKS ticks.
module countdown_timer_core
   import timer_pkg::*;
#(
   parameter logic [7:0] DEF_MIN     = DEF_MIN_VAL,
   parameter logic [7:0] DEF_SEC     = DEF_SEC_VAL,
   parameter logic [7:0] MAX_MIN     = MAX_MIN_VAL,
   parameter int         LED_W       = LED_W_VAL,
   parameter int         ALARM_TICKS = ALARM_TICKS_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             setting,
   input  logic             pb_start,
   input  logic             pb_stop,
   input  logic             pb_sec_add,
   input  logic             pb_min_add,
   input  logic             dir_up,
   output logic [7:0]       min,
   output logic [7:0]       sec,
   output logic             running,
   output logic             done,
   output logic [LED_W-1:0] led
);

   state_t           r_state;
   logic [7:0]       r_pre_min;
   logic [7:0]       r_pre_sec;
   logic             r_dir_up;
   logic             r_running;
   logic             r_done;
   logic [LED_W-1:0] r_led;

   logic [7:0] w_min;
   logic [7:0] w_sec;
   logic [7:0] w_load_min;
   logic [7:0] w_load_sec;
   logic [7:0] w_up_min;
   logic [7:0] w_up_sec;
   logic       w_sec_wrap;
   logic       w_min_wrap;
   logic       w_start;
   logic       w_tick_run;
   logic       w_pre_zero;
   logic       w_term;
   logic       w_auto_ret;
   logic       w_to_idle;
   logic       w_cnt_load;

`ifdef ALARM_BLINK_EN
   localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);
   logic [7:0] r_alarm_cnt;
   assign w_auto_ret = (r_state == DONE) && tick && !pb_stop && !pb_start &&
                       (r_alarm_cnt == ALARM_LAST);
`else
   assign w_auto_ret = 1'b0;
`endif

   assign w_start    = pb_start && !pb_stop;
   assign w_tick_run = (r_state == RUN) && tick && !pb_stop;
   assign w_pre_zero = (r_pre_min == BCD_ZERO) && (r_pre_sec == BCD_ZERO);
   assign w_to_idle  = (r_state != IDLE) &&
                       (pb_stop || ((r_state == DONE) && pb_start) || w_auto_ret);
   // IDLE tracks the preset every cycle; any return to IDLE reloads it at once
   assign w_cnt_load = (r_state == IDLE) || w_to_idle;

   // count load value: 00:00 when starting upward, preset otherwise
   always_comb begin
      if ((r_state == IDLE) && w_start && dir_up) begin
         w_load_min = BCD_ZERO;
         w_load_sec = BCD_ZERO;
      end else begin
         w_load_min = r_pre_min;
         w_load_sec = r_pre_sec;
      end
   end

   // terminal detection on the value the current tick would produce
   always_comb begin
      w_up_sec = bcd_step_up(w_sec, BCD_59);
      if (w_sec == BCD_59)
         w_up_min = bcd_step_up(w_min, MAX_MIN);
      else
         w_up_min = w_min;
      if (r_dir_up)
         w_term = ((w_up_min == r_pre_min) && (w_up_sec == r_pre_sec)) || w_min_wrap;
      else
         w_term = ((w_min == BCD_ZERO) && (w_sec == 8'h01)) || w_min_wrap;
   end

   bcd_mod_counter #(.RST_VAL(DEF_SEC)) u_sec (
      .clk      (clk),
      .rst      (rst),
      .load     (w_cnt_load),
      .load_val (w_load_sec),
      .inc      (w_tick_run && r_dir_up),
      .dec      (w_tick_run && !r_dir_up),
      .mod_max  (BCD_59),
      .cnt      (w_sec),
      .wrap     (w_sec_wrap)
   );

   bcd_mod_counter #(.RST_VAL(DEF_MIN)) u_min (
      .clk      (clk),
      .rst      (rst),
      .load     (w_cnt_load),
      .load_val (w_load_min),
      .inc      (w_tick_run && r_dir_up && w_sec_wrap),
      .dec      (w_tick_run && !r_dir_up && w_sec_wrap),
      .mod_max  (MAX_MIN),
      .cnt      (w_min),
      .wrap     (w_min_wrap)
   );

   countdown_timer_core_chk #(
      .DEF_MIN     (DEF_MIN),
      .DEF_SEC     (DEF_SEC),
      .MAX_MIN     (MAX_MIN),
      .ALARM_TICKS (ALARM_TICKS)
   ) u_chk (
      .clk (clk),
      .rst (rst)
   );

   // control FSM with preset registers and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pre_min <= DEF_MIN;
         r_pre_sec <= DEF_SEC;
         r_dir_up  <= 1'b0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
         r_led     <= {LED_W{1'b0}};
`ifdef ALARM_BLINK_EN
         r_alarm_cnt <= 8'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (setting && pb_sec_add)
                  r_pre_sec <= bcd_step_up(r_pre_sec, BCD_59);
               if (setting && pb_min_add)
                  r_pre_min <= bcd_step_up(r_pre_min, MAX_MIN);
               if (w_start) begin
                  r_dir_up <= dir_up;
                  if (w_pre_zero) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_led   <= {LED_W{1'b1}};
`ifdef ALARM_BLINK_EN
                     r_alarm_cnt <= 8'd0;
`endif
                  end else begin
                     r_state   <= RUN;
                     r_running <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (pb_stop) begin
                  r_state   <= IDLE;
                  r_running <= 1'b0;
               end else if (tick && w_term) begin
                  r_state   <= DONE;
                  r_running <= 1'b0;
                  r_done    <= 1'b1;
                  r_led     <= {LED_W{1'b1}};
`ifdef ALARM_BLINK_EN
                  r_alarm_cnt <= 8'd0;
`endif
               end else if (pb_start) begin
                  r_state   <= PAUSE;
                  r_running <= 1'b0;
               end
            end
            PAUSE: begin
               if (pb_stop) begin
                  r_state <= IDLE;
               end else if (pb_start) begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
               end
            end
            DONE: begin
               if (pb_stop || pb_start || w_auto_ret) begin
                  r_state <= IDLE;
                  r_done  <= 1'b0;
                  r_led   <= {LED_W{1'b0}};
               end
`ifdef ALARM_BLINK_EN
               else if (tick) begin
                  r_alarm_cnt <= r_alarm_cnt + 8'd1;
                  r_led       <= ~r_led;
               end
`endif
            end
            default: begin
               r_state   <= IDLE;
               r_running <= 1'b0;
               r_done    <= 1'b0;
               r_led     <= {LED_W{1'b0}};
            end
         endcase
      end
   end

   assign min     = w_min;
   assign sec     = w_sec;
   assign running = r_running;
   assign done    = r_done;
   assign led     = r_led;

endmodule

// File: doc/countdown_timer_core.md
Name: countdown_timer_core

Overview:
- Parametrised mm:ss timer core with a run/pause/stop FSM, presettable limit, up or down count direction, and an alarm LED bank.
- Sits between the debounced push-button pulses and a 1 Hz tick enable on one side, and the seven-segment decoders and LEDs on the other.
- Successor to the fixed 23:59 down-only timer: runs on a single clock with a tick enable instead of a divided clock domain, and adds count-up mode, a DONE state and generic widths.

Parameters:
- DEF_MIN, 8'h23: reset preset minutes, BCD.
- DEF_SEC, 8'h59: reset preset seconds, BCD.
- MAX_MIN, 8'h99: highest settable minute value, BCD.
- LED_W, 16: alarm LED width.
- ALARM_TICKS, 10: ticks spent in DONE before auto-return to IDLE (ALARM_BLINK_EN only).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- tick  in  1  one-cycle 1 Hz enable.
- setting  in  1  level; 1 = preset editing allowed.
- pb_start  in  1  one-cycle pulse; start/pause toggle.
- pb_stop  in  1  one-cycle pulse; stop/reload.
- pb_sec_add  in  1  one-cycle pulse; preset seconds +1.
- pb_min_add  in  1  one-cycle pulse; preset minutes +1.
- dir_up  in  1  level; 1 = count up from 00:00 to preset, 0 = count down from preset to 00:00.
- min  out  8  displayed minutes, BCD {tens,units}.
- sec  out  8  displayed seconds, BCD.
- running  out  1  high in RUN.
- done  out  1  high in DONE.
- led  out  LED_W  alarm LEDs.

Behaviour:
- Reset (async, rst=1):
  - state IDLE; preset = DEF_MIN:DEF_SEC; min:sec = preset.
  - running, done and led all 0; direction latch 0.
- All other state updates on the rising clk edge.
- States: IDLE, RUN, PAUSE, DONE (2-bit encoding).
- IDLE:
  - min:sec shows the preset (registered, 1-cycle latency after a preset change).
  - If setting=1: pb_sec_add steps preset sec 00..59 and wraps 59->00 with no carry into minutes; pb_min_add steps preset min 00..MAX_MIN and wraps to 00. Both pulses in the same cycle apply both increments.
  - pb_start: latch dir_up and go to RUN. The count loads preset (down) or 00:00 (up).
  - If the loaded count already equals the terminal value (down with preset 00:00, or up with preset 00:00), go straight to DONE.
- RUN, on each tick:
  - Down: sec decrements, 00 -> 59 with a borrow that decrements min.
  - Up: sec increments, 59 -> 00 with a carry that increments min. min never exceeds MAX_MIN.
  - Terminal is 00:00 (down) or equal to the preset (up). The tick that produces the terminal value also moves the FSM to DONE on the same edge. done and led assert the next cycle.
- RUN, other events:
  - pb_start -> PAUSE.
  - pb_stop -> IDLE; count reloads the preset display.
- PAUSE:
  - tick ignored; count held.
  - pb_start -> RUN (direction stays latched).
  - pb_stop -> IDLE.
- DONE:
  - Count held at terminal value; led all ones.
  - pb_stop or pb_start -> IDLE.
- Priorities and ignored inputs:
  - pb_stop beats pb_start, which beats tick.
  - If tick and pb_start arrive together in RUN, the tick is applied and the FSM then moves to PAUSE.
  - dir_up changes outside IDLE are ignored.
  - Add pulses outside IDLE, or with setting=0, are ignored.
- BCD rule: nibbles are always valid BCD (0-9). Non-BCD parameter values are illegal and trapped by an assertion.

Optional Feature:
- Macro: ALARM_BLINK_EN.
- Defined:
  - In DONE, led toggles between all ones and all zeros on each tick, starting at all ones.
  - After ALARM_TICKS ticks the FSM auto-returns to IDLE.
  - Needs an 8-bit tick counter, cleared on DONE entry.
- Undefined:
  - led is solid all ones for the whole of DONE.
  - No auto-return.

Decomposition:
- Package timer_pkg holds:
  - the state typedef (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - BCD constants (BCD_59=8'h59, BCD_ZERO=8'h00);
  - the default parameter values.
- Sub-module bcd_mod_counter, a 2-digit BCD counter:
  - inputs: load, load_val, inc, dec, mod_max;
  - output: wrap flag, high on the cycle it wraps;
  - instantiated twice: seconds with mod_max=59, minutes with mod_max=MAX_MIN.

Test Plan:
- Reset with defaults: min=8'h23, sec=8'h59, led=0. Assert rst mid-RUN and check the same values appear asynchronously.
- Preset editing: setting=1, 3x pb_sec_add from 59 gives sec=02 and min unchanged; pb_min_add at 99 gives min=00.
- Down count: preset 01:01, start, 2 ticks gives 00:59. After 59 more ticks the count is 00:00, done=1 and led=16'hFFFF. pb_stop returns to 01:01.
- Up count: dir_up=1, preset 00:03, start, 3 ticks gives 00:03, then DONE. A dir_up toggle during RUN has no effect.
- Pause/priority:
  - In RUN, pulse pb_start together with tick: count decrements once, then no further change over 5 ticks.
  - pb_start and pb_stop together go to IDLE.
- ALARM_BLINK_EN with ALARM_TICKS=4: led reads FFFF, 0000, FFFF, 0000 on successive ticks, then IDLE with led=0 and the preset shown.
